// File: rtl/cpu_clk_sched.sv
// cpu_clk_sched
// Generates the 65816 clock (cpu_phi2) in the hsclk domain and sequences two
// kinds of CPU cycle:
//   - fast local SRAM/internal cycles, where each phi2 half-phase lasts
//     FAST_DIV hsclk cycles;
//   - host (BBC) bus cycles, where phi2 is held low until the synchronised
//     host phi0 has completed a falling and then a rising edge, and phi2 then
//     follows phi0 high.
// Every output is a flop, so downstream pins see clean edges.
//
// Ports:
//   hsclk_i        high-speed clock, all state on its rising edge
//   rst_i          asynchronous active-high reset
//   host_phi0_i    host phi0, asynchronous to hsclk
//   cpu_valid_i    cpu_vda|cpu_vpa, valid while cpu_phi2 is low
//   host_sel_i     current address decodes to host space
//   cpu_rnw_i      CPU read/not-write
//   cpu_phi2_o     CPU clock
//   ram_ceb_o      SRAM chip select, active low
//   ram_oeb_o      SRAM output enable, active low
//   ram_web_o      SRAM write enable, active low
//   host_cyc_o     high for the whole host cycle (enables BBC bus drivers)
//   host_dlatch_o  one-hsclk pulse to latch host read data
//   fast_mode_o    high while running fast cycles
module cpu_clk_sched #(
  parameter int unsigned FAST_DIV    = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic hsclk_i,
  input  logic rst_i,
  input  logic host_phi0_i,
  input  logic cpu_valid_i,
  input  logic host_sel_i,
  input  logic cpu_rnw_i,
  output logic cpu_phi2_o,
  output logic ram_ceb_o,
  output logic ram_oeb_o,
  output logic ram_web_o,
  output logic host_cyc_o,
  output logic host_dlatch_o,
  output logic fast_mode_o
);

  typedef enum logic [2:0] {
    F_LO   = 3'd0,
    F_HI   = 3'd1,
    H_WAIT = 3'd2,
    H_LO   = 3'd3,
    H_HI   = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(FAST_DIV - 1);

  state_t                 state_q;
  logic [3:0]             count_q;
  logic [3:0]             count_d;
  logic [SYNC_STAGES-1:0] syncChain_q;
  logic                   phi0Dly_q;
  logic                   phaseIsRam_q;
  logic                   cpuPhi2_q;
  logic                   ramCeb_q;
  logic                   ramOeb_q;
  logic                   ramWeb_q;
  logic                   hostCyc_q;
  logic                   hostDlatch_q;
  logic                   fastMode_q;

  logic phi0S;
  logic phi0Rise;
  logic phi0Fall;
  logic phi0FallNext;
  logic countLast;
  logic enterLastHi;
  logic ramDecision;

  // Edge detection on the synchronised phi0. phi0FallNext looks one stage
  // further up the chain so that the data-latch strobe can be registered and
  // still land exactly in the cycle where the fall is seen.
  always_comb begin
    phi0S        = syncChain_q[SYNC_STAGES-1];
    phi0Rise     = phi0S & ~phi0Dly_q;
    phi0Fall     = ~phi0S & phi0Dly_q;
    phi0FallNext = phi0S & ~syncChain_q[SYNC_STAGES-2];
    count_d      = count_q + 4'd1;
    countLast    = (count_q == CNT_LAST);
    enterLastHi  = (count_d == CNT_LAST);
    ramDecision  = cpu_valid_i & ~host_sel_i;
  end

  // Synchroniser, phase counter and cycle-type state machine. Outputs are
  // loaded together with the state they belong to, so each output register
  // always reflects the state the machine is in during that cycle.
  always_ff @(posedge hsclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= F_LO;
      count_q      <= 4'd0;
      syncChain_q  <= '0;
      phi0Dly_q    <= 1'b0;
      phaseIsRam_q <= 1'b0;
      cpuPhi2_q    <= 1'b0;
      ramCeb_q     <= 1'b1;
      ramOeb_q     <= 1'b1;
      ramWeb_q     <= 1'b1;
      hostCyc_q    <= 1'b0;
      hostDlatch_q <= 1'b0;
      fastMode_q   <= 1'b1;
    end else begin
      syncChain_q  <= {syncChain_q[SYNC_STAGES-2:0], host_phi0_i};
      phi0Dly_q    <= phi0S;
      hostDlatch_q <= 1'b0;

      case (state_q)
        F_LO: begin
          if (countLast) begin
            // The cycle type is decided only here; later changes of
            // host_sel/cpu_valid cannot turn this cycle into a host cycle.
            count_q      <= 4'd0;
            phaseIsRam_q <= ramDecision;
            if (cpu_valid_i && host_sel_i) begin
              state_q    <= H_WAIT;
              hostCyc_q  <= 1'b1;
              fastMode_q <= 1'b0;
            end else begin
              state_q   <= F_HI;
              cpuPhi2_q <= 1'b1;
              ramCeb_q  <= ~ramDecision;
              ramOeb_q  <= ~(ramDecision & cpu_rnw_i);
              ramWeb_q  <= ~(ramDecision & ~cpu_rnw_i);
            end
          end else begin
            count_q <= count_d;
          end
        end

        F_HI: begin
          if (countLast) begin
            state_q   <= F_LO;
            count_q   <= 4'd0;
            cpuPhi2_q <= 1'b0;
            ramCeb_q  <= 1'b1;
            ramOeb_q  <= 1'b1;
            ramWeb_q  <= 1'b1;
          end else begin
            // The final high cycle releases write enable early so the SRAM
            // sees write recovery before phi2 falls.
            count_q  <= count_d;
            ramCeb_q <= ~phaseIsRam_q;
            ramOeb_q <= ~(phaseIsRam_q & cpu_rnw_i);
            ramWeb_q <= enterLastHi ? 1'b1 : ~(phaseIsRam_q & ~cpu_rnw_i);
          end
        end

        H_WAIT: begin
          // Rising edges here are ignored so the host cycle always begins
          // at the start of a host phase 1.
          if (phi0Fall) begin
            state_q <= H_LO;
          end
        end

        H_LO: begin
          if (phi0Rise) begin
            state_q      <= H_HI;
            cpuPhi2_q    <= 1'b1;
            hostDlatch_q <= phi0FallNext & cpu_rnw_i;
          end
        end

        H_HI: begin
          if (phi0Fall) begin
            state_q    <= F_LO;
            count_q    <= 4'd0;
            cpuPhi2_q  <= 1'b0;
            hostCyc_q  <= 1'b0;
            fastMode_q <= 1'b1;
          end else begin
            hostDlatch_q <= phi0FallNext & cpu_rnw_i;
          end
        end

        default: begin
          state_q    <= F_LO;
          count_q    <= 4'd0;
          cpuPhi2_q  <= 1'b0;
          ramCeb_q   <= 1'b1;
          ramOeb_q   <= 1'b1;
          ramWeb_q   <= 1'b1;
          hostCyc_q  <= 1'b0;
          fastMode_q <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_phi2_o    = cpuPhi2_q;
  assign ram_ceb_o     = ramCeb_q;
  assign ram_oeb_o     = ramOeb_q;
  assign ram_web_o     = ramWeb_q;
  assign host_cyc_o    = hostCyc_q;
  assign host_dlatch_o = hostDlatch_q;
  assign fast_mode_o   = fastMode_q;

endmodule

// File: tb/tb_cpu_clk_sched.sv
// tb_cpu_clk_sched
// Drives two schedulers (FAST_DIV=2 and FAST_DIV=3) from shared inputs.
// Every CPU cycle (phi2 low phase followed by its high phase) is summarised
// by the monitor and compared with a hand-computed expectation queued by the
// stimulus. Cycle numbers in the comments count from the first hsclk period
// after reset release (cycle 0).
module tb_cpu_clk_sched;

  logic hsclk    = 1'b0;
  logic rst      = 1'b0;
  logic hostPhi0 = 1'b1;
  logic cpuValid = 1'b0;
  logic hostSel  = 1'b0;
  logic cpuRnw   = 1'b1;

  logic [1:0] phi2W;
  logic [1:0] cebW;
  logic [1:0] oebW;
  logic [1:0] webW;
  logic [1:0] hostW;
  logic [1:0] dlW;
  logic [1:0] fastW;
  logic [1:0] monEn = 2'b00;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [7:0] lowW;
    logic [7:0] highW;
    logic [7:0] cebLow;
    logic [7:0] oebLow;
    logic [7:0] webLow;
    logic [7:0] webLast;
    logic [7:0] hostLo;
    logic [7:0] hostHi;
    logic [7:0] fastHi;
    logic [7:0] dlatch;
    logic [7:0] clash;
  } phase_t;

  phase_t expQ0[$];
  phase_t expQ1[$];
  phase_t acc[2];
  logic   prevPhi[2];

  // 16 MHz-style hsclk; host phi0 is stepped in whole hsclk cycles so the
  // synchroniser latency is exactly predictable.
  always #5 hsclk = ~hsclk;

  cpu_clk_sched #(.FAST_DIV(2), .SYNC_STAGES(2)) dut0 (
    .hsclk_i(hsclk), .rst_i(rst), .host_phi0_i(hostPhi0),
    .cpu_valid_i(cpuValid), .host_sel_i(hostSel), .cpu_rnw_i(cpuRnw),
    .cpu_phi2_o(phi2W[0]), .ram_ceb_o(cebW[0]), .ram_oeb_o(oebW[0]),
    .ram_web_o(webW[0]), .host_cyc_o(hostW[0]), .host_dlatch_o(dlW[0]),
    .fast_mode_o(fastW[0])
  );

  cpu_clk_sched #(.FAST_DIV(3), .SYNC_STAGES(2)) dut1 (
    .hsclk_i(hsclk), .rst_i(rst), .host_phi0_i(hostPhi0),
    .cpu_valid_i(cpuValid), .host_sel_i(hostSel), .cpu_rnw_i(cpuRnw),
    .cpu_phi2_o(phi2W[1]), .ram_ceb_o(cebW[1]), .ram_oeb_o(oebW[1]),
    .ram_web_o(webW[1]), .host_cyc_o(hostW[1]), .host_dlatch_o(dlW[1]),
    .fast_mode_o(fastW[1])
  );

  function automatic phase_t mkPhase(input int lowW, input int highW,
                                     input int cebLow, input int oebLow,
                                     input int webLow, input int webLast,
                                     input int hostLo, input int hostHi,
                                     input int fastHi, input int dl);
    phase_t p;
    p.lowW    = 8'(lowW);
    p.highW   = 8'(highW);
    p.cebLow  = 8'(cebLow);
    p.oebLow  = 8'(oebLow);
    p.webLow  = 8'(webLow);
    p.webLast = 8'(webLast);
    p.hostLo  = 8'(hostLo);
    p.hostHi  = 8'(hostHi);
    p.fastHi  = 8'(fastHi);
    p.dlatch  = 8'(dl);
    p.clash   = 8'd0;
    return p;
  endfunction

  function automatic int qSize(input int d);
    return (d == 0) ? expQ0.size() : expQ1.size();
  endfunction

  task automatic pushExp(input int d, input phase_t p);
    if (d == 0) expQ0.push_back(p);
    else        expQ1.push_back(p);
  endtask

  // Pops the oldest expectation for this DUT and compares a finished phase.
  task automatic comparePhase(input int d, input phase_t got);
    phase_t e;
    checks++;
    if (qSize(d) == 0) begin
      $display("[TB] FAIL phase dut%0d: got unexpected phase low=%0d high=%0d, required no phase", d, got.lowW, got.highW);
    end else begin
      if (d == 0) e = expQ0.pop_front();
      else        e = expQ1.pop_front();
      if (got == e) begin
        passes++;
      end else begin
        $display("[TB] FAIL phase dut%0d: got low=%0d hi=%0d ceb=%0d oeb=%0d web=%0d webLast=%0d hostLo=%0d hostHi=%0d fast=%0d dl=%0d clash=%0d, required low=%0d hi=%0d ceb=%0d oeb=%0d web=%0d webLast=%0d hostLo=%0d hostHi=%0d fast=%0d dl=%0d clash=%0d",
                 d, got.lowW, got.highW, got.cebLow, got.oebLow, got.webLow, got.webLast,
                 got.hostLo, got.hostHi, got.fastHi, got.dlatch, got.clash,
                 e.lowW, e.highW, e.cebLow, e.oebLow, e.webLow, e.webLast,
                 e.hostLo, e.hostHi, e.fastHi, e.dlatch, e.clash);
      end
    end
  endtask

  // Accumulates one mid-cycle sample into the running phase summary; a
  // phase is complete when phi2 is seen low again after being high.
  task automatic sampleDut(input int d);
    if (rst) begin
      acc[d]     = '0;
      prevPhi[d] = 1'b0;
    end else begin
      if (prevPhi[d] && !phi2W[d]) begin
        if (monEn[d]) comparePhase(d, acc[d]);
        acc[d] = '0;
      end
      if (phi2W[d]) begin
        acc[d].highW   = acc[d].highW + 8'd1;
        if (!cebW[d])  acc[d].cebLow = acc[d].cebLow + 8'd1;
        if (!oebW[d])  acc[d].oebLow = acc[d].oebLow + 8'd1;
        if (!webW[d])  acc[d].webLow = acc[d].webLow + 8'd1;
        acc[d].webLast = {7'd0, webW[d]};
        if (hostW[d])  acc[d].hostHi = acc[d].hostHi + 8'd1;
        if (fastW[d])  acc[d].fastHi = acc[d].fastHi + 8'd1;
      end else begin
        acc[d].lowW = acc[d].lowW + 8'd1;
        if (hostW[d]) acc[d].hostLo = acc[d].hostLo + 8'd1;
      end
      if (dlW[d])              acc[d].dlatch = acc[d].dlatch + 8'd1;
      if (!cebW[d] && hostW[d]) acc[d].clash = acc[d].clash + 8'd1;
      prevPhi[d] = phi2W[d];
    end
  endtask

  task automatic runMonitor();
    forever begin
      @(negedge hsclk);
      for (int d = 0; d < 2; d++) sampleDut(d);
    end
  endtask

  // Sets inputs for the current cycle, then advances to 1 time unit after
  // the next rising edge.
  task automatic applyStimulus(input logic v, input logic s, input logic r, input logic p);
    cpuValid = v;
    hostSel  = s;
    cpuRnw   = r;
    hostPhi0 = p;
    @(posedge hsclk);
    #1;
  endtask

  // Compares {phi2, ceb, oeb, web, host_cyc, dlatch, fast_mode} directly.
  task automatic checkOutput(input int d, input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {phi2W[d], cebW[d], oebW[d], webW[d], hostW[d], dlW[d], fastW[d]};
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s dut%0d: got %b, required %b", name, d, got, exp);
  endtask

  task automatic resetDut();
    monEn = 2'b00;
    rst   = 1'b1;
    @(posedge hsclk);
    @(posedge hsclk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitDrain(input int d);
    int t;
    t = 0;
    while (qSize(d) != 0 && t < 100) begin
      @(posedge hsclk);
      #1;
      t++;
    end
    if (qSize(d) != 0) begin
      checks++;
      $display("[TB] FAIL drain dut%0d: %0d phases still pending after %0d cycles, required 0", d, qSize(d), t);
    end
    monEn = 2'b00;
  endtask

  initial begin
    fork
      runMonitor();
    join_none

    #2 rst = 1'b1;
    #20;
    $display("[TB] reset state");
    checkOutput(0, "reset-state", 7'b0111001);
    checkOutput(1, "reset-state", 7'b0111001);

    // Idle cycles at FAST_DIV=2: 2 low / 2 high, no strobes.
    $display("[TB] idle fast cycles");
    resetDut();
    for (int i = 0; i < 3; i++) pushExp(0, mkPhase(2, 2, 0, 0, 0, 1, 0, 0, 2, 0));
    monEn = 2'b01;
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitDrain(0);

    // RAM read at FAST_DIV=2: ceb and oeb low for both high cycles.
    $display("[TB] RAM read");
    resetDut();
    for (int i = 0; i < 2; i++) pushExp(0, mkPhase(2, 2, 2, 2, 0, 1, 0, 0, 2, 0));
    monEn = 2'b01;
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitDrain(0);

    // RAM write at FAST_DIV=3: web low for 2 of 3 high cycles.
    $display("[TB] RAM write, FAST_DIV=3");
    resetDut();
    for (int i = 0; i < 2; i++) pushExp(1, mkPhase(3, 3, 3, 0, 2, 1, 0, 0, 3, 0));
    monEn = 2'b10;
    for (int k = 0; k < 12; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    waitDrain(1);

    // Host read then back-to-back host write. phi0 is low in cycles 3-6,
    // 11-14, 19-22, 27-30 (8-cycle period). Read: H_WAIT 2-5, H_LO 6-9,
    // H_HI 10-13 with dlatch in 13. Write: F_LO 14-15, H_WAIT 16-21,
    // H_LO 22-25, H_HI 26-29.
    $display("[TB] host read and write");
    resetDut();
    pushExp(0, mkPhase(10, 4, 0, 0, 0, 1, 8, 4, 0, 1));
    pushExp(0, mkPhase(12, 4, 0, 0, 0, 1, 10, 4, 0, 0));
    monEn = 2'b01;
    for (int k = 0; k < 30; k++)
      applyStimulus(1'b1, 1'b1, k < 14, ((k + 1) % 8) < 4);
    waitDrain(0);

    // Reset asserted in H_HI (cycle 11) acts before the next clock edge.
    $display("[TB] reset during host cycle");
    resetDut();
    for (int k = 0; k < 11; k++)
      applyStimulus(1'b1, 1'b1, 1'b1, ((k + 1) % 8) < 4);
    checkOutput(0, "pre-reset-hhi", 7'b1111100);
    rst = 1'b1;
    #1;
    checkOutput(0, "async-reset-hhi", 7'b0111001);
    @(posedge hsclk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) pushExp(0, mkPhase(2, 2, 0, 0, 0, 1, 0, 0, 2, 0));
    monEn = 2'b01;
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitDrain(0);

    // host_sel high everywhere except the decision cycles, with phi0
    // toggling every cycle: every cycle must stay a fast RAM read.
    $display("[TB] host_sel outside decision cycle");
    resetDut();
    for (int i = 0; i < 3; i++) pushExp(0, mkPhase(2, 2, 2, 2, 0, 1, 0, 0, 2, 0));
    monEn = 2'b01;
    for (int k = 0; k < 12; k++)
      applyStimulus(1'b1, (k % 4) != 1, 1'b1, (k % 2) == 1);
    waitDrain(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
